down_counter4bit: RTL and testbench



---
 rtl/down_counter4bit.sv | 138 +++++++++++++
 tb/tb_down_counter4bit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/down_counter4bit.sv
// ---------------------------------------------------------------------------
// down_counter4bit - loadable 4-bit countdown timer
//
// Loads a start value and counts down once per enabled cycle. When it
// reaches zero it pulses done for one cycle. The decrement is built from
// a ripple chain of fulladder1 cells that adds all-ones (Q + 4'b1111).
//
// Parameters:
//   AUTO_RELOAD - 1: reload load_val and keep running after done
//                 0: return to idle after done
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset, overrides everything
//   start    in   load load_val and begin counting (IDLE or DONE only)
//   load_val in   start value 0..15, sampled only on a loading edge
//   en       in   count enable while in RUN
//   Q        out  current count (registered)
//   busy     out  high while in RUN (registered)
//   done     out  one-cycle pulse in DONE (registered)
//   zero     out  Q == 0 (combinational)
// ---------------------------------------------------------------------------

// One-bit full adder used as the decrement datapath cell.
module fulladder1 (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module down_counter4bit #(
    parameter logic AUTO_RELOAD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic [3:0] Q,
    output logic       busy,
    output logic       done,
    output logic       zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_q;
    logic [3:0] q_q;
    logic       busy_q;
    logic       done_q;

    // Decrement datapath: Q + 4'b1111 with carry-in 0 yields Q - 1.
    logic [3:0] dec_sum;
    logic [4:0] carry;
    logic       borrow;

    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dec
            fulladder1 u_fa (
                .a_i  (q_q[gi]),
                .b_i  (1'b1),
                .ci_i (carry[gi]),
                .s_o  (dec_sum[gi]),
                .co_o (carry[gi+1])
            );
        end
    endgenerate

    // Adding all-ones carries out for every nonzero Q; no carry means Q was 0.
    assign borrow = ~carry[4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            q_q     <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (load_val != 4'd0) begin
                            q_q     <= load_val;
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            // Zero-length run: straight to DONE, busy never rises.
                            q_q     <= 4'd0;
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else if ((state_q == ST_DONE) && AUTO_RELOAD &&
                                 (load_val != 4'd0)) begin
                        q_q     <= load_val;
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // The borrow guard keeps Q from ever wrapping 0 -> 15.
                    if (en && !borrow) begin
                        q_q <= dec_sum;
                        if (q_q == 4'd1) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Q    = q_q;
    assign busy = busy_q;
    assign done = done_q;
    assign zero = (q_q == 4'd0);

endmodule

// File: tb/tb_down_counter4bit.sv
module tb_down_counter4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] load_val;
    logic       en;
    logic [3:0] q, q_ar;
    logic       busy, busy_ar;
    logic       done, done_ar;
    logic       zero, zero_ar;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    down_counter4bit #(.AUTO_RELOAD(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .load_val(load_val), .en(en),
        .Q(q), .busy(busy), .done(done), .zero(zero)
    );

    down_counter4bit #(.AUTO_RELOAD(1'b1)) dut_ar (
        .clk(clk), .rst(rst), .start(start), .load_val(load_val), .en(en),
        .Q(q_ar), .busy(busy_ar), .done(done_ar), .zero(zero_ar)
    );

    // Advance one active edge, then settle before sampling / driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; load_val = 4'd7; en = 1'b1;
        tick(); tick();
        n_checks++; if (q !== 4'd0)   begin n_fail++; $display("FAIL reset_q got %0d exp 0", q); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got %b exp 1", zero); end
        n_checks++; if (q_ar !== 4'd0) begin n_fail++; $display("FAIL reset_q_ar got %0d exp 0", q_ar); end
        $display("reset: Q=%0d busy=%b done=%b zero=%b", q, busy, done, zero);
        rst = 1'b0; start = 1'b0; en = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        start = 1'b1; load_val = 4'd5; en = 1'b1;
        tick(); // edge 0
        start = 1'b0; load_val = 4'd9; // must not affect the running count
        n_checks++; if (q !== 4'd5)    begin n_fail++; $display("FAIL basic_load_q got %0d exp 5", q); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_load_busy got %b exp 1", busy); end
        n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL basic_load_zero got %b exp 0", zero); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            $display("basic: edge %0d Q=%0d busy=%b done=%b", k, q, busy, done);
            n_checks++; if (q !== 4'(5 - k)) begin n_fail++; $display("FAIL basic_q edge %0d got %0d exp %0d", k, q, 5 - k); end
            n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL basic_flags edge %0d got busy=%b done=%b exp 1/0", k, busy, done); end
        end
        tick(); // edge 5
        n_checks++; if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b1 || zero !== 1'b1) begin
            n_fail++; $display("FAIL basic_done got Q=%0d busy=%b done=%b zero=%b exp 0/0/1/1", q, busy, done, zero); end
        tick();
        n_checks++; if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL basic_idle got Q=%0d busy=%b done=%b exp 0/0/0", q, busy, done); end
        $display("basic: idle Q=%0d", q);
    endtask

    task automatic test_enable_gating();
        logic [3:0] exp_q [6];
        logic       exp_en [6];
        exp_q  = '{4'd3, 4'd2, 4'd2, 4'd2, 4'd1, 4'd0};
        exp_en = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}; // en seen on edges 0..5
        start = 1'b1; load_val = 4'd3;
        for (int e = 0; e < 6; e++) begin
            en = exp_en[e];
            tick();
            start = 1'b0;
            $display("gating: edge %0d en=%b Q=%0d busy=%b done=%b", e, en, q, busy, done);
            n_checks++; if (q !== exp_q[e]) begin n_fail++; $display("FAIL gating_q edge %0d got %0d exp %0d", e, q, exp_q[e]); end
            n_checks++; if (done !== (e == 5)) begin n_fail++; $display("FAIL gating_done edge %0d got %b exp %b", e, done, e == 5); end
        end
        en = 1'b1;
        tick();
    endtask

    task automatic test_zero_load();
        start = 1'b1; load_val = 4'd0;
        tick();
        start = 1'b0;
        $display("zero_load: Q=%0d busy=%b done=%b", q, busy, done);
        n_checks++; if (done !== 1'b1 || busy !== 1'b0 || q !== 4'd0) begin
            n_fail++; $display("FAIL zero_load got Q=%0d busy=%b done=%b exp 0/0/1", q, busy, done); end
        tick();
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_load_after got busy=%b done=%b exp 0/0", busy, done); end
    endtask

    task automatic test_max();
        start = 1'b1; load_val = 4'd15; en = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (q !== 4'd15) begin n_fail++; $display("FAIL max_load got %0d exp 15", q); end
        for (int k = 1; k <= 15; k++) begin
            tick();
            n_checks++; if (q !== 4'(15 - k)) begin n_fail++; $display("FAIL max_q edge %0d got %0d exp %0d", k, q, 15 - k); end
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL max_done got %b exp 1", done); end
        $display("max: after 15 decrements Q=%0d done=%b", q, done);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (q !== 4'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL max_nowrap got Q=%0d busy=%b exp 0/0", q, busy); end
        end
    endtask

    task automatic test_restart_ignore();
        start = 1'b1; load_val = 4'd4; en = 1'b1;
        tick(); // edge 0, Q=4
        load_val = 4'd9; // start still high: must be ignored in RUN
        tick();
        start = 1'b0;
        $display("restart: start in RUN -> Q=%0d busy=%b", q, busy);
        n_checks++; if (q !== 4'd3 || busy !== 1'b1) begin n_fail++; $display("FAIL ignore_start got Q=%0d busy=%b exp 3/1", q, busy); end
        tick(); tick(); // Q=2, Q=1
        tick(); // Q=0, DONE
        n_checks++; if (done !== 1'b1 || q !== 4'd0) begin n_fail++; $display("FAIL restart_done got Q=%0d done=%b exp 0/1", q, done); end
        start = 1'b1; load_val = 4'd2;
        tick();
        start = 1'b0;
        $display("restart: start in DONE -> Q=%0d busy=%b done=%b", q, busy, done);
        n_checks++; if (q !== 4'd2 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL b2b_load got Q=%0d busy=%b done=%b exp 2/1/0", q, busy, done); end
        tick();
        n_checks++; if (q !== 4'd1) begin n_fail++; $display("FAIL b2b_q got %0d exp 1", q); end
        tick();
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done got busy=%b done=%b exp 0/1", busy, done); end
        tick();
    endtask

    task automatic test_abort();
        start = 1'b1; load_val = 4'd3; en = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); // Q=1 in RUN
        n_checks++; if (q !== 4'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre got Q=%0d busy=%b exp 1/1", q, busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("abort: Q=%0d busy=%b done=%b zero=%b", q, busy, done, zero);
        n_checks++; if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || zero !== 1'b1) begin
            n_fail++; $display("FAIL abort got Q=%0d busy=%b done=%b zero=%b exp 0/0/0/1", q, busy, done, zero); end
        tick();
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_after got busy=%b done=%b exp 0/0", busy, done); end
    endtask

    task automatic test_auto_reload();
        rst = 1'b1; start = 1'b0; en = 1'b0;
        tick();
        rst = 1'b0;
        start = 1'b1; load_val = 4'd2; en = 1'b1;
        for (int e = 0; e < 9; e++) begin
            tick();
            start = 1'b0;
            $display("auto_reload: edge %0d Q=%0d busy=%b done=%b", e, q_ar, busy_ar, done_ar);
            n_checks++; if (q_ar !== 4'(2 - (e % 3))) begin n_fail++; $display("FAIL ar_q edge %0d got %0d exp %0d", e, q_ar, 2 - (e % 3)); end
            n_checks++; if (done_ar !== ((e % 3) == 2)) begin n_fail++; $display("FAIL ar_done edge %0d got %b exp %b", e, done_ar, (e % 3) == 2); end
            n_checks++; if (busy_ar !== ((e % 3) != 2)) begin n_fail++; $display("FAIL ar_busy edge %0d got %b exp %b", e, busy_ar, (e % 3) != 2); end
        end
        // The non-reloading instance ran the same stimulus once and stopped.
        n_checks++; if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL noreload_idle got Q=%0d busy=%b done=%b exp 0/0/0", q, busy, done); end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; load_val = 4'd0; en = 1'b0;
        test_reset();
        test_basic();
        test_enable_gating();
        test_zero_load();
        test_max();
        test_restart_ignore();
        test_abort();
        test_auto_reload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
